fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
- Collects audio samples from the DSP front end into a ping-pong frame buffer of two banks, each FFT_LEN samples deep.
- Streams each completed frame into the FFT core's sink interface over valid/ready, with correct sop/eop framing.
- Sits between the audio DSP stage and the FFT controller datapath, so the FFT always receives whole, gap-free-in-content frames.
- Flags sample loss when both banks are full.

Parameters:
- FFT_LEN, 2048, samples per frame; power of two, >= 4.
- DW, 16, sample width in bits.
- AW, $clog2(FFT_LEN), bank address width (derived).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; synchronous, active-high
- i_sample_valid  in  1  one-cycle strobe; i_sample is valid this cycle
- i_sample  in  DW  audio sample, two's complement
- o_sink_valid  out  1  sink beat valid
- i_sink_ready  in  1  FFT sink ready
- o_sink_data  out  DW  real part of beat (imag/size/inverse are packed by the parent)
- o_sink_sop  out  1  high on beat 0 of a frame, qualified by o_sink_valid
- o_sink_eop  out  1  high on beat FFT_LEN-1, qualified by o_sink_valid
- o_frame_sent  out  1  one-cycle pulse after the eop handshake
- o_overflow  out  1  sticky: a sample was dropped
- i_clr_overflow  in  1  clears o_overflow
- o_busy  out  1  read FSM not in S_IDLE

Behaviour:
- Reset: applied on a clock edge with i_rst=1.
  - All outputs go to 0.
  - wr_bank=0, rd_bank=0, wr_ptr=0, rd_ptr=0, full[1:0]=0, FSM=S_IDLE.
  - RAM contents are don't-care.
- Reset mid-frame: the stream aborts with no eop; the next frame starts with sop. The FFT core shares i_rst.
- Storage: 2*FFT_LEN x DW synchronous-read RAM with 1-cycle read latency.
- Write side, on i_sample_valid:
  - If full[wr_bank]=0: write mem[wr_bank][wr_ptr] and increment wr_ptr.
  - When wr_ptr=FFT_LEN-1: set full[wr_bank], wr_ptr wraps to 0, wr_bank toggles.
  - If full[wr_bank]=1: drop the sample, set o_overflow, leave wr_ptr unchanged.
- o_overflow:
  - Set has priority over i_clr_overflow in the same cycle.
  - Otherwise i_clr_overflow clears it on the next edge.
- Read FSM:
  - S_IDLE: if full[rd_bank], go to S_FETCH with rd_ptr=0.
  - S_FETCH: drive RAM address {rd_bank, rd_ptr}; next edge go to S_STREAM, register data into o_sink_data, set o_sink_valid=1.
  - S_STREAM: o_sink_valid=1; o_sink_data, sop and eop are held stable until i_sink_ready=1.
  - On handshake with rd_ptr<FFT_LEN-1: o_sink_valid=0, rd_ptr++, go to S_FETCH.
  - On handshake with rd_ptr=FFT_LEN-1: o_sink_valid=0, clear full[rd_bank], toggle rd_bank, pulse o_frame_sent next cycle, go to S_IDLE.
- Framing: o_sink_sop = valid & (rd_ptr==0); o_sink_eop = valid & (rd_ptr==FFT_LEN-1).
- Throughput: at most one beat per 2 cycles. There is always exactly one idle cycle between beats, sufficient since the sample rate is far below the clock.
- Latency: when the last sample of a frame is written at edge T, o_sink_valid with sop rises at edge T+2, provided the FSM is idle and the bank is rd_bank.
- Frame order: banks are emitted strictly in fill order, starting with bank 0.
- Simultaneous events:
  - Write completing one bank while read releases the other in the same cycle: both flag updates apply.
  - A sample arriving on the same edge that full[wr_bank] clears is dropped and sets o_overflow, because the flag is registered.
- o_busy = (state != S_IDLE).

Test Plan:
- Reset check: assert i_rst for 2 cycles during activity -> every output is 0 on the next cycle.
- Single frame (FFT_LEN=2048, ready=1): strobe samples 0..2047 -> o_sink_valid rises 2 cycles after the last strobe; beat 0 has data 0 with sop=1; beat 2047 has data 2047 with eop=1; 2048 beats each followed by one idle cycle; o_frame_sent pulses once; o_busy then 0.
- Backpressure (FFT_LEN=8): hold ready=0 for 10 cycles when beat 3 (data 3) is presented -> valid=1 and data=3 stay stable all 10 cycles; sop=eop=0; beat 3 is accepted on the first ready=1 cycle.
- Overflow (FFT_LEN=8, ready=0): write 16 samples, then 1 more (value 99) -> o_overflow=1 and 99 is never emitted. Release ready -> frame 0..7 then 8..15 emitted in order, o_frame_sent pulses twice. Pulse i_clr_overflow -> o_overflow=0.
- Ping-pong concurrency (FFT_LEN=8, ready=1): write continuously at 1 sample per 4 cycles for 3 frames -> no overflow; 3 frames emitted in order with correct sop/eop.
- Reset mid-stream (FFT_LEN=8): assert i_rst at beat 4 -> valid=0 next cycle. Write 8 new samples -> the new frame starts with sop and contains only the new data.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Ping-pong frame buffer between the audio DSP stage and the FFT sink.
// Collects FFT_LEN-sample frames into two banks and streams whole frames out with sop/eop framing.
module fft_frame_sequencer #(
  parameter int unsigned FFT_LEN = 2048,
  parameter int unsigned DW      = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_sample_valid,
  input  logic [DW-1:0] i_sample,
  output logic          o_sink_valid,
  input  logic          i_sink_ready,
  output logic [DW-1:0] o_sink_data,
  output logic          o_sink_sop,
  output logic          o_sink_eop,
  output logic          o_frame_sent,
  output logic          o_overflow,
  input  logic          i_clr_overflow,
  output logic          o_busy
);

  localparam int unsigned AW   = $clog2(FFT_LEN);
  localparam logic [AW-1:0] LAST = AW'(FFT_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM} state_t;

  state_t        state, state_next;
  logic [DW-1:0] mem [2*FFT_LEN];
  logic          wr_bank, rd_bank;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    full, full_next;

  logic wr_accept, wr_drop, wr_last;
  logic start, fetch, handshake, beat_last;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (full[rd_bank]) state_next = S_FETCH;
      S_FETCH:  state_next = S_STREAM;
      S_STREAM: if (i_sink_ready) state_next = (rd_ptr == LAST) ? S_IDLE : S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  // Control strobes; a bank is only written while its full flag is clear
  always_comb begin
    wr_accept = i_sample_valid & ~full[wr_bank];
    wr_drop   = i_sample_valid &  full[wr_bank];
    wr_last   = wr_accept & (wr_ptr == LAST);
    start     = (state == S_IDLE) & full[rd_bank];
    fetch     = (state == S_FETCH);
    handshake = (state == S_STREAM) & i_sink_ready;
    beat_last = handshake & (rd_ptr == LAST);
    full_next = full;
    if (beat_last) full_next[rd_bank] = 1'b0;
    if (wr_last)   full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (wr_accept) mem[{wr_bank, wr_ptr}] <= i_sample;
  end

  // Synchronous RAM read doubles as the output data register
  always_ff @(posedge i_clk) begin
    if (i_rst)      o_sink_data <= '0;
    else if (fetch) o_sink_data <= mem[{rd_bank, rd_ptr}];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      full         <= '0;
      o_sink_valid <= 1'b0;
      o_sink_sop   <= 1'b0;
      o_sink_eop   <= 1'b0;
      o_frame_sent <= 1'b0;
      o_overflow   <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      if (wr_accept) begin
        if (wr_ptr == LAST) begin
          wr_ptr  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
      full <= full_next;

      if (start)                       rd_ptr <= '0;
      else if (handshake && !beat_last) rd_ptr <= rd_ptr + AW'(1);
      if (beat_last) rd_bank <= ~rd_bank;

      // sop/eop ride with valid and hold until the beat is taken
      if (fetch) begin
        o_sink_valid <= 1'b1;
        o_sink_sop   <= (rd_ptr == '0);
        o_sink_eop   <= (rd_ptr == LAST);
      end else if (handshake) begin
        o_sink_valid <= 1'b0;
        o_sink_sop   <= 1'b0;
        o_sink_eop   <= 1'b0;
      end

      o_frame_sent <= beat_last;
      if (wr_drop)             o_overflow <= 1'b1;
      else if (i_clr_overflow) o_overflow <= 1'b0;
      o_busy <= (state_next != S_IDLE);
    end
  end

endmodule
